gf_poly_div: RTL and testbench

- Sequential GF(2^SIZE) polynomial long divider; the inverse operation of gf_poly_mul.
- Divides a degree-2n dividend by a degree-n divisor and returns quotient (n+1 coeffs) and remainder (n coeffs).
- Sits in the Reed-Solomon datapath for syndrome/remainder computation and for checking gf_poly_mul products.
- Uses the existing gf_mul for all field multiplies; computes the inverse of the divisor's leading coefficient iteratively.

---
 rtl/gf_poly_div_if.sv | 26 ++
 rtl/gf_poly_div.sv | 219 +++++++++++++++++++++
 tb/tb_gf_poly_div.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gf_poly_div_if.sv
// Request/result bundle for the GF(2^SIZE) polynomial divider.
// Latency: none, wires only.
// Backpressure: none; the master watches busy/done, and starts issued while busy are dropped.
interface gf_poly_div_if #(
  parameter int SIZE = 8,
  parameter int n    = 2
);
  logic                        start;
  logic [(2*n+1)*SIZE-1:0]     flat_z;
  logic [(n+1)*SIZE-1:0]       flat_d;
  logic                        busy;
  logic                        done;
  logic                        div_err;
  logic [(n+1)*SIZE-1:0]       flat_q;
  logic [n*SIZE-1:0]           flat_r;

  modport master (
    output start, flat_z, flat_d,
    input  busy, done, div_err, flat_q, flat_r
  );

  modport slave (
    input  start, flat_z, flat_d,
    output busy, done, div_err, flat_q, flat_r
  );
endinterface

// File: rtl/gf_poly_div.sv
// Sequential GF(2^SIZE) polynomial long divider: degree-2n dividend / degree-n divisor -> quotient, remainder.
// Latency: done pulses after edge SIZE+n (start edge = 0); zero leading divisor coeff -> done after edge 1.
// Backpressure: none; start is only sampled in IDLE and is dropped (not queued) while an operation runs.

// Combinational GF(2^SIZE) multiplier, shift-and-add with reduction by POLY.
module gf_mul #(
  parameter int SIZE = 8,
  parameter int POLY = 'h11D
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] p
);
  localparam logic [SIZE-1:0] RED = SIZE'(POLY);

  logic [SIZE-1:0] sh;

  // Accumulate a*x^i for each set bit of b, reducing a*x^i modulo the field polynomial as it shifts.
  always_comb begin
    p  = '0;
    sh = a;
    for (int i = 0; i < SIZE; i++) begin
      if (b[i]) p = p ^ sh;
      sh = sh[SIZE-1] ? ((sh << 1) ^ RED) : (sh << 1);
    end
  end
endmodule

module gf_poly_div #(
  parameter int m    = 255,
  parameter int SIZE = $clog2(m),
  parameter int n    = 2,
  parameter int POLY = 'h11D
) (
  input  logic         clk,
  input  logic         rst,
  gf_poly_div_if.slave bus
);
  // Index widths sized exactly to the arrays they address.
  localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;
  localparam int QW = $clog2(n + 1);
  localparam int AW = $clog2(2*n + 1);

  typedef enum logic [1:0] {IDLE, INV, DIV, DONE} state_t;

  state_t state;

  // Working registers: running remainder, captured divisor, quotient under construction.
  logic [SIZE-1:0] r  [0:2*n];
  logic [SIZE-1:0] dr [0:n];
  logic [SIZE-1:0] q  [0:n];

  // Inversion by repeated squaring: sq walks d^(2^i), acc collects d^(2^(i+1)-2).
  logic [SIZE-1:0] sq;
  logic [SIZE-1:0] acc;
  logic [CW-1:0]   inv_cnt;
  logic [QW-1:0]   k;

  // Registered outputs.
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [(n+1)*SIZE-1:0] q_flat;
  logic [n*SIZE-1:0]     r_flat;

  // Combinational datapath.
  logic [SIZE-1:0]       d_lead;
  logic [SIZE-1:0]       sq2;
  logic [SIZE-1:0]       acc_nxt;
  logic [SIZE-1:0]       r_lead;
  logic [SIZE-1:0]       c;
  logic [AW-1:0]         lead_idx;
  logic [SIZE-1:0]       prod  [0:n];
  logic [SIZE-1:0]       r_nxt [0:2*n];
  logic [SIZE-1:0]       q_nxt [0:n];
  logic [(n+1)*SIZE-1:0] q_flat_nxt;
  logic [n*SIZE-1:0]     r_flat_nxt;

  assign d_lead = bus.flat_d[n*SIZE +: SIZE];

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.div_err = err_q;
  assign bus.flat_q  = q_flat;
  assign bus.flat_r  = r_flat;

  // Inversion multipliers: square, then fold the square into the accumulator.
  gf_mul #(.SIZE(SIZE), .POLY(POLY)) u_sq  (.a(sq),  .b(sq),  .p(sq2));
  gf_mul #(.SIZE(SIZE), .POLY(POLY)) u_acc (.a(acc), .b(sq2), .p(acc_nxt));

  // Division multipliers: quotient coefficient, then one product per divisor coefficient.
  gf_mul #(.SIZE(SIZE), .POLY(POLY)) u_c (.a(r_lead), .b(acc), .p(c));

  for (genvar j = 0; j <= n; j++) begin : g_prod
    gf_mul #(.SIZE(SIZE), .POLY(POLY)) u_p (.a(c), .b(dr[j]), .p(prod[j]));
  end

  // Select the remainder coefficient being eliminated this step.
  always_comb begin
    lead_idx = AW'(k) + AW'(n);
    r_lead   = r[lead_idx];
  end

  // Next remainder/quotient for the current step; the prod[n] term cancels r[k+n] exactly.
  always_comb begin
    for (int i = 0; i <= 2*n; i++) begin
      r_nxt[i] = r[i];
    end
    for (int j = 0; j <= n; j++) begin
      r_nxt[AW'(k) + AW'(j)] = r[AW'(k) + AW'(j)] ^ prod[j];
    end
    for (int i = 0; i <= n; i++) begin
      q_nxt[i] = q[i];
    end
    q_nxt[k] = c;
  end

  // Flatten the step results so the last DIV edge can publish them directly.
  always_comb begin
    q_flat_nxt = '0;
    r_flat_nxt = '0;
    for (int i = 0; i <= n; i++) begin
      q_flat_nxt[i*SIZE +: SIZE] = q_nxt[i];
    end
    for (int i = 0; i < n; i++) begin
      r_flat_nxt[i*SIZE +: SIZE] = r_nxt[i];
    end
  end

  // Control FSM and working registers; outputs only change on accept and on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sq      <= '0;
      acc     <= '0;
      inv_cnt <= '0;
      k       <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      q_flat  <= '0;
      r_flat  <= '0;
      for (int i = 0; i <= 2*n; i++) begin
        r[i] <= '0;
      end
      for (int i = 0; i <= n; i++) begin
        dr[i] <= '0;
        q[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            if (d_lead != '0) begin
              for (int i = 0; i <= 2*n; i++) begin
                r[i] <= bus.flat_z[i*SIZE +: SIZE];
              end
              for (int i = 0; i <= n; i++) begin
                dr[i] <= bus.flat_d[i*SIZE +: SIZE];
              end
              sq      <= d_lead;
              acc     <= SIZE'(1);
              inv_cnt <= '0;
              k       <= QW'(n);
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              state   <= INV;
            end else begin
              // Division by a zero leading coefficient: report it with zeroed results.
              err_q  <= 1'b1;
              q_flat <= '0;
              r_flat <= '0;
              state  <= DONE;
            end
          end
        end

        INV: begin
          sq      <= sq2;
          acc     <= acc_nxt;
          inv_cnt <= inv_cnt + CW'(1);
          if (inv_cnt == CW'(SIZE - 2)) state <= DIV;
        end

        DIV: begin
          for (int i = 0; i <= 2*n; i++) begin
            r[i] <= r_nxt[i];
          end
          for (int i = 0; i <= n; i++) begin
            q[i] <= q_nxt[i];
          end
          if (k == '0) begin
            q_flat <= q_flat_nxt;
            r_flat <= r_flat_nxt;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            k <= k - QW'(1);
          end
        end

        DONE: begin
          // Normal entry arrives with done already raised; the error path raises it here,
          // which gives that path its one-cycle settle before the pulse.
          if (done_q) begin
            done_q <= 1'b0;
            state  <= IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gf_poly_div.sv
// Bench for gf_poly_div: directed vectors pushed to a scoreboard, a monitor pops on each done pulse.
// Latency: expected done latency travels with each scoreboard entry.
// Backpressure: none; each vector is drained before the next is issued.
module tb_gf_poly_div;
  localparam int SIZE = 8;
  localparam int N    = 2;
  localparam int ZW   = (2*N+1)*SIZE;
  localparam int DW   = (N+1)*SIZE;
  localparam int RW   = N*SIZE;

  typedef struct {
    logic [DW-1:0] q;
    logic [RW-1:0] r;
    logic          err;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gf_poly_div_if #(.SIZE(SIZE), .n(N)) bus ();

  gf_poly_div #(.m(255), .SIZE(SIZE), .n(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   start_cyc = 0;
  exp_t sb [$];
  exp_t mon_e;
  logic prev_done = 1'b0;

  // Edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent GF(2^8) multiply, poly x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      b  = b >> 1;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1D;
    end
    return p;
  endfunction

  task automatic issue(input logic [ZW-1:0] z, input logic [DW-1:0] d);
    @(negedge clk);
    bus.flat_z = z;
    bus.flat_d = d;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    start_cyc  = cyc;
    // Operands are captured on the accepting edge only; scramble them afterwards.
    bus.flat_z = ZW'({$urandom, $urandom});
    bus.flat_d = DW'($urandom);
  endtask

  task automatic push(input logic [DW-1:0] q, input logic [RW-1:0] r, input logic err, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.err = err; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got %0d results outstanding, expected 0", name, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      chk("done_width", 32'(prev_done), 32'd0);
      chk("busy_at_done", 32'(bus.busy), 32'd0);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", 32'(bus.flat_q), 32'(mon_e.q));
        chk("remainder", 32'(bus.flat_r), 32'(mon_e.r));
        chk("div_err", 32'(bus.div_err), 32'(mon_e.err));
        chk("latency", 32'(cyc - start_cyc), 32'(mon_e.lat));
      end
    end
    prev_done = bus.done;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]    qq [0:N];
    logic [7:0]    rr [0:N-1];
    logic [7:0]    dd [0:N];
    logic [7:0]    zz [0:2*N];
    logic [ZW-1:0] zf;
    logic [DW-1:0] df;
    logic [DW-1:0] qf;
    logic [RW-1:0] rf;
    logic [7:0]    v;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.flat_z = '0;
    bus.flat_d = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_div_err", 32'(bus.div_err), 32'd0);
    chk("rst_q", 32'(bus.flat_q), 32'd0);
    chk("rst_r", 32'(bus.flat_r), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // d = x^2, z = [5,6,7,8,9] -> q = [7,8,9], r = [5,6]
    issue({8'd9, 8'd8, 8'd7, 8'd6, 8'd5}, {8'd1, 8'd0, 8'd0});
    push({8'd9, 8'd8, 8'd7}, {8'd6, 8'd5}, 1'b0, 10);
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    drain("shift");

    // d = x^2+x+1, z = x^4 -> q = [0,1,1], r = [0,1]
    issue({8'd1, 8'd0, 8'd0, 8'd0, 8'd0}, {8'd1, 8'd1, 8'd1});
    push({8'd1, 8'd1, 8'd0}, {8'd1, 8'd0}, 1'b0, 10);
    drain("x4");

    // Zero leading coefficient: error, zeroed results, busy never raised.
    issue({8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, {8'd0, 8'd4, 8'd3});
    push('0, '0, 1'b1, 1);
    repeat (3) begin
      chk("busy_err", 32'(bus.busy), 32'd0);
      @(negedge clk);
    end
    drain("err");

    // Non-monic divisor d = 2x^2, z = 2x^2 -> q = 1, r = 0
    issue({8'd0, 8'd0, 8'd2, 8'd0, 8'd0}, {8'd2, 8'd0, 8'd0});
    push({8'd0, 8'd0, 8'd1}, '0, 1'b0, 10);
    drain("nonmonic");

    // Zero dividend
    issue('0, {8'd3, 8'd2, 8'd1});
    push('0, '0, 1'b0, 10);
    drain("zero_z");

    // Start pulsed during INV with different operands must be ignored.
    issue({8'd9, 8'd8, 8'd7, 8'd6, 8'd5}, {8'd1, 8'd0, 8'd0});
    push({8'd9, 8'd8, 8'd7}, {8'd6, 8'd5}, 1'b0, 10);
    repeat (2) @(negedge clk);
    bus.flat_z = {8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    bus.flat_d = {8'd1, 8'd1, 8'd1};
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    drain("ignored_start");
    repeat (5) @(negedge clk);
    chk("hold_q", 32'(bus.flat_q), 32'({8'd9, 8'd8, 8'd7}));
    chk("hold_r", 32'(bus.flat_r), 32'({8'd6, 8'd5}));

    // Reset during DIV: no done pulse, everything cleared.
    issue({8'd1, 8'd0, 8'd0, 8'd0, 8'd0}, {8'd1, 8'd1, 8'd1});
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_q", 32'(bus.flat_q), 32'd0);
    chk("abort_r", 32'(bus.flat_r), 32'd0);
    repeat (15) @(negedge clk);
    issue({8'd1, 8'd0, 8'd0, 8'd0, 8'd0}, {8'd1, 8'd1, 8'd1});
    push({8'd1, 8'd1, 8'd0}, {8'd1, 8'd0}, 1'b0, 10);
    drain("after_abort");

    // Sweep every nonzero leading coefficient with z = d -> q = 1, r = 0.
    for (int i = 1; i < 256; i++) begin
      v  = 8'(i);
      df = {v, v ^ 8'h5A, 8'(i * 3)};
      issue({16'd0, df}, df);
      push({8'd0, 8'd0, 8'd1}, '0, 1'b0, 10);
      drain("sweep");
    end

    // Random: build z = q*d + r from random q, r, d; division must recover q and r.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i <= N; i++) qq[i] = 8'($urandom);
      for (int i = 0; i < N; i++)  rr[i] = 8'($urandom);
      for (int i = 0; i < N; i++)  dd[i] = 8'($urandom);
      dd[N] = 8'($urandom_range(1, 255));
      for (int i = 0; i <= 2*N; i++) zz[i] = 8'h00;
      for (int i = 0; i <= N; i++)
        for (int j = 0; j <= N; j++)
          zz[i+j] ^= gmul(qq[i], dd[j]);
      for (int i = 0; i < N; i++) zz[i] ^= rr[i];
      zf = '0; df = '0; qf = '0; rf = '0;
      for (int i = 0; i <= 2*N; i++) zf[i*8 +: 8] = zz[i];
      for (int i = 0; i <= N; i++)   df[i*8 +: 8] = dd[i];
      for (int i = 0; i <= N; i++)   qf[i*8 +: 8] = qq[i];
      for (int i = 0; i < N; i++)    rf[i*8 +: 8] = rr[i];
      issue(zf, df);
      push(qf, rf, 1'b0, 10);
      drain("random");
      repeat (3) @(negedge clk);
      chk("random_hold_q", 32'(bus.flat_q), 32'(qf));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
